// File: rtl/keypad_code_entry_if.sv
// Keypad-to-controller signal bundle for keypad_code_entry.
// The slave modport is the entry block; the master modport drives keys and reads the code.
interface keypad_code_entry_if;
    logic        vehicle_arrival;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [15:0] code;
    logic        code_ack;
    logic [2:0]  digit_count;
    logic        entry_error;

    modport master (
        output vehicle_arrival, key_valid, key_code,
        input  code, code_ack, digit_count, entry_error
    );

    modport slave (
        input  vehicle_arrival, key_valid, key_code,
        output code, code_ack, digit_count, entry_error
    );
endinterface

// File: rtl/keypad_code_entry.sv
// Four-digit keypad code entry FSM (IDLE/ENTRY/SUBMIT/HOLD) feeding a downstream controller.
// Define KEYPAD_TIMEOUT_EN to clear a stale partial entry after TIMEOUT_CYCLES of inactivity.
module keypad_code_entry #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd1000
) (
    input  logic              clk,
    input  logic              rst,
    keypad_code_entry_if.slave kp
);
    typedef enum logic [1:0] {IDLE, ENTRY, SUBMIT, HOLD} state_t;

    state_t      state;
    logic [15:0] buffer;
    logic [15:0] code_q;
    logic        code_ack_q;
    logic        entry_error_q;
    logic [2:0]  count_q;

    logic is_digit, is_clear, is_enter, timed_out;

    assign is_digit = kp.key_valid && (kp.key_code <= 4'h9);
    assign is_clear = kp.key_valid && (kp.key_code == 4'hA);
    assign is_enter = kp.key_valid && (kp.key_code == 4'hB);

`ifdef KEYPAD_TIMEOUT_EN
    logic [15:0] idle_timer;

    // Only a partial entry with no key activity this cycle can time out.
    assign timed_out = (state == ENTRY) && (count_q != 3'd0) && kp.vehicle_arrival &&
                       !(is_digit || is_clear || is_enter) &&
                       (idle_timer == TIMEOUT_CYCLES - 16'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_timer <= '0;
        end else if (state != ENTRY || count_q == 3'd0 || !kp.vehicle_arrival ||
                     is_digit || is_clear || is_enter || timed_out) begin
            idle_timer <= '0;
        end else begin
            idle_timer <= idle_timer + 16'd1;
        end
    end
`else
    assign timed_out = 1'b0;
`endif

    // NOTE: every register here uses <= so all next-state terms read the pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            buffer        <= '0;
            code_q        <= '0;
            code_ack_q    <= 1'b0;
            entry_error_q <= 1'b0;
            count_q       <= '0;
        end else begin
            code_ack_q    <= 1'b0;
            entry_error_q <= 1'b0;
            if (state != IDLE && !kp.vehicle_arrival) begin
                state   <= IDLE;
                buffer  <= '0;
                count_q <= '0;
                code_q  <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (kp.vehicle_arrival) state <= ENTRY;
                    end
                    ENTRY: begin
                        if (is_digit) begin
                            if (count_q != 3'd4) begin
                                buffer  <= {buffer[11:0], kp.key_code};
                                count_q <= count_q + 3'd1;
                            end
                        end else if (is_clear) begin
                            buffer  <= '0;
                            count_q <= '0;
                        end else if (is_enter) begin
                            if (count_q == 3'd4) begin
                                state      <= SUBMIT;
                                code_q     <= buffer;
                                code_ack_q <= 1'b1;
                            end else begin
                                entry_error_q <= 1'b1;
                                buffer        <= '0;
                                count_q       <= '0;
                            end
                        end else if (timed_out) begin
                            entry_error_q <= 1'b1;
                            buffer        <= '0;
                            count_q       <= '0;
                        end
                    end
                    SUBMIT: begin
                        state <= HOLD;
                    end
                    HOLD: begin
                        // A new digit starts a fresh entry; enter is ignored here.
                        if (is_digit) begin
                            state   <= ENTRY;
                            buffer  <= {12'h000, kp.key_code};
                            count_q <= 3'd1;
                            code_q  <= '0;
                        end else if (is_clear) begin
                            state   <= ENTRY;
                            buffer  <= '0;
                            count_q <= '0;
                            code_q  <= '0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign kp.code        = code_q;
    assign kp.code_ack    = code_ack_q;
    assign kp.digit_count = count_q;
    assign kp.entry_error = entry_error_q;
endmodule

// File: tb/tb_keypad_code_entry.sv
// Directed, table-driven bench for keypad_code_entry plus hand-written reset/timeout sequences.
module tb_keypad_code_entry;
    logic clk;
    logic rst;
    keypad_code_entry_if kp ();

    keypad_code_entry #(.TIMEOUT_CYCLES(16'd16)) dut (
        .clk (clk),
        .rst (rst),
        .kp  (kp.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        va;
        logic        kv;
        logic [3:0]  kc;
        logic [15:0] code;
        logic        ack;
        logic [2:0]  cnt;
        logic        err;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_errors = 0;

    function automatic void add(input logic va, input logic kv, input logic [3:0] kc,
                                input logic [15:0] code, input logic ack,
                                input logic [2:0] cnt, input logic err);
        vec_t v;
        v.va = va; v.kv = kv; v.kc = kc;
        v.code = code; v.ack = ack; v.cnt = cnt; v.err = err;
        vecs.push_back(v);
    endfunction

    function automatic logic [20:0] observed();
        return {kp.code, kp.code_ack, kp.digit_count, kp.entry_error};
    endfunction

    task automatic check(input string name, input logic [20:0] act, input logic [20:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got code=%h ack=%b cnt=%0d err=%b, expected code=%h ack=%b cnt=%0d err=%b",
                     name, act[20:5], act[4], act[3:1], act[0], exp[20:5], exp[4], exp[3:1], exp[0]);
        end
    endtask

    task automatic step(input logic va, input logic kv, input logic [3:0] kc);
        kp.vehicle_arrival = va;
        kp.key_valid       = kv;
        kp.key_code        = kc;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Basic entry 5990, enter ignored in HOLD
        add(1, 0, 4'h0, 16'h0000, 0, 0, 0);
        add(1, 1, 4'h5, 16'h0000, 0, 1, 0);
        add(1, 1, 4'h9, 16'h0000, 0, 2, 0);
        add(1, 1, 4'h9, 16'h0000, 0, 3, 0);
        add(1, 1, 4'h0, 16'h0000, 0, 4, 0);
        add(1, 1, 4'hB, 16'h5990, 1, 4, 0);
        add(1, 0, 4'h0, 16'h5990, 0, 4, 0);
        add(1, 1, 4'hB, 16'h5990, 0, 4, 0);
        // Short submit rejected, then retry 1234
        add(1, 1, 4'h1, 16'h0000, 0, 1, 0);
        add(1, 1, 4'h2, 16'h0000, 0, 2, 0);
        add(1, 1, 4'hB, 16'h0000, 0, 0, 1);
        add(1, 1, 4'h1, 16'h0000, 0, 1, 0);
        add(1, 1, 4'h2, 16'h0000, 0, 2, 0);
        add(1, 1, 4'h3, 16'h0000, 0, 3, 0);
        add(1, 1, 4'h4, 16'h0000, 0, 4, 0);
        add(1, 1, 4'hB, 16'h1234, 1, 4, 0);
        add(1, 0, 4'h0, 16'h1234, 0, 4, 0);
        // Clear from HOLD, 5th digit ignored, 3145
        add(1, 1, 4'hA, 16'h0000, 0, 0, 0);
        add(1, 1, 4'h3, 16'h0000, 0, 1, 0);
        add(1, 0, 4'h0, 16'h0000, 0, 1, 0);
        add(1, 1, 4'h1, 16'h0000, 0, 2, 0);
        add(1, 1, 4'h4, 16'h0000, 0, 3, 0);
        add(1, 1, 4'h5, 16'h0000, 0, 4, 0);
        add(1, 1, 4'h6, 16'h0000, 0, 4, 0);
        add(1, 1, 4'hB, 16'h3145, 1, 4, 0);
        add(1, 0, 4'h0, 16'h3145, 0, 4, 0);
        // 7, clear, enter -> error only
        add(1, 1, 4'h7, 16'h0000, 0, 1, 0);
        add(1, 1, 4'hA, 16'h0000, 0, 0, 0);
        add(1, 1, 4'hB, 16'h0000, 0, 0, 1);
        // Codes C-F ignored
        add(1, 1, 4'h8, 16'h0000, 0, 1, 0);
        add(1, 1, 4'hC, 16'h0000, 0, 1, 0);
        add(1, 1, 4'hF, 16'h0000, 0, 1, 0);
        add(1, 1, 4'hA, 16'h0000, 0, 0, 0);
        // Arrival drop beats a simultaneous key; keys ignored in IDLE
        add(1, 1, 4'h5, 16'h0000, 0, 1, 0);
        add(0, 1, 4'h9, 16'h0000, 0, 0, 0);
        add(0, 1, 4'h3, 16'h0000, 0, 0, 0);
        add(1, 1, 4'h4, 16'h0000, 0, 0, 0);
        add(1, 1, 4'h4, 16'h0000, 0, 1, 0);
        // Arrival drop in SUBMIT clears the code
        add(1, 1, 4'hA, 16'h0000, 0, 0, 0);
        add(1, 1, 4'h2, 16'h0000, 0, 1, 0);
        add(1, 1, 4'h0, 16'h0000, 0, 2, 0);
        add(1, 1, 4'h2, 16'h0000, 0, 3, 0);
        add(1, 1, 4'h4, 16'h0000, 0, 4, 0);
        add(1, 1, 4'hB, 16'h2024, 1, 4, 0);
        add(0, 0, 4'h0, 16'h0000, 0, 0, 0);
        add(0, 1, 4'h5, 16'h0000, 0, 0, 0);

        rst = 1'b1;
        kp.vehicle_arrival = 1'b0;
        kp.key_valid       = 1'b0;
        kp.key_code        = 4'h0;
        repeat (5) @(posedge clk);
        #1;
        check("reset_state", observed(), 21'h0);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].va, vecs[i].kv, vecs[i].kc);
            check($sformatf("vec[%0d]", i), observed(),
                  {vecs[i].code, vecs[i].ack, vecs[i].cnt, vecs[i].err});
        end

        // Reset asserted during SUBMIT drops the pending ack at once
        step(1, 0, 4'h0);
        step(1, 1, 4'h9);
        step(1, 1, 4'h8);
        step(1, 1, 4'h7);
        step(1, 1, 4'h6);
        step(1, 1, 4'hB);
        check("submit_9876", observed(), {16'h9876, 1'b1, 3'd4, 1'b0});
        rst = 1'b1;
        #1;
        check("rst_in_submit", observed(), 21'h0);
        step(1, 1, 4'h1);
        check("rst_held_ignores_keys", observed(), 21'h0);
        rst = 1'b0;
        step(1, 0, 4'h0);
        check("arrive_after_rst", observed(), 21'h0);
        step(1, 1, 4'h3);
        check("first_key_after_rst", observed(), {16'h0000, 1'b0, 3'd1, 1'b0});

        // Stale partial entry: kept forever unless the timeout is built in
        repeat (20) step(1, 0, 4'h0);
`ifdef KEYPAD_TIMEOUT_EN
        check("inactivity", observed(), {16'h0000, 1'b0, 3'd0, 1'b0});
`else
        check("inactivity", observed(), {16'h0000, 1'b0, 3'd1, 1'b0});
`endif

        // Reset mid-entry
        step(1, 1, 4'h4);
        rst = 1'b1;
        #1;
        check("rst_mid_entry", observed(), 21'h0);
        rst = 1'b0;
        step(0, 0, 4'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/keypad_code_entry.md
KEYPAD_CODE_ENTRY -- requirements
Module: keypad_code_entry

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16'd1000: inactivity limit in clk cycles, used only when KEYPAD_TIMEOUT_EN is defined.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 vehicle_arrival  input  1  level; entry is enabled only while high.
REQ-005 key_valid  input  1  one-cycle strobe; key_code is valid in that cycle.
REQ-006 key_code  input  4  4'h0-4'h9 digit; 4'hA clear; 4'hB enter; 4'hC-4'hF ignored.
REQ-007 code  output  16  four packed BCD digits, first-entered digit in [15:12], fed to the downstream controller.
REQ-008 code_ack  output  1  one-cycle pulse; code is valid in that cycle.
REQ-009 digit_count  output  3  number of digits currently buffered, 0-4.
REQ-010 entry_error  output  1  one-cycle pulse on a rejected submit or a timeout.

Function
REQ-011 The block SHALL implement states IDLE, ENTRY, SUBMIT and HOLD.
REQ-012 IDLE -> ENTRY on the first clk with vehicle_arrival=1; all keys SHALL be ignored in IDLE.
REQ-013 In ENTRY, an accepted digit SHALL shift the buffer left: buf <= {buf[11:0], key_code}, with digit_count incremented.
REQ-014 When digit_count=4, further digits SHALL be ignored: buffer and count unchanged, no error.
REQ-015 Clear (4'hA) SHALL zero the buffer and digit_count in the next cycle, and the state SHALL remain ENTRY.
REQ-016 Enter (4'hB) with digit_count=4 SHALL go to SUBMIT; code=buf and code_ack=1 for exactly one cycle, registered, 1 cycle after the key strobe.
REQ-017 Enter with digit_count<4 SHALL pulse entry_error for one cycle, clear the buffer, and stay in ENTRY; code_ack SHALL stay 0.
REQ-018 SUBMIT -> HOLD unconditionally; in HOLD, code SHALL keep the submitted value.
REQ-019 HOLD -> ENTRY on the next accepted digit or clear, with the buffer reset before that digit is applied; enter in HOLD SHALL be ignored.
REQ-020 A second attempt after rejection (e.g. 1234, then 3145) SHALL produce an independent code_ack pulse.
REQ-021 vehicle_arrival=0 in any non-IDLE state SHALL force IDLE next cycle, clearing the buffer, digit_count and code; this SHALL take priority over a simultaneous key_valid.
REQ-022 Keys with codes 4'hC-4'hF SHALL be ignored in all states.
REQ-023 code SHALL read 16'h0000 except from SUBMIT through HOLD.

Reset
REQ-024 rst=1 SHALL asynchronously force IDLE, code=16'h0, code_ack=0, digit_count=0, entry_error=0, buffer=0, and the timeout counter=0.
REQ-025 rst asserted mid-entry or during SUBMIT SHALL drop any pending code_ack; the first key is accepted on the first clk edge after rst deasserts.

Configuration
REQ-026 With KEYPAD_TIMEOUT_EN defined, a 16-bit counter SHALL count in ENTRY while digit_count>0 and reset on every accepted key.
REQ-027 When the counter reaches TIMEOUT_CYCLES-1, the block SHALL clear the buffer and count and pulse entry_error once.
REQ-028 Without KEYPAD_TIMEOUT_EN, no counter SHALL be synthesized, TIMEOUT_CYCLES SHALL be unused, and a partial entry SHALL persist indefinitely.

Verification
REQ-029 rst=1 for 5 cycles, then release; vehicle_arrival=1; keys 5,9,9,0,B -> code=16'h5990 with a single-cycle code_ack, 1 cycle after B; digit_count=4.
REQ-030 Keys 1,2,B -> entry_error pulse, code_ack=0, digit_count=0; then keys 1,2,3,4,B -> code=16'h1234 with code_ack.
REQ-031 Keys 3,1,4,5,6,B -> code=16'h3145, with the 5th digit ignored; keys 7,A,B -> entry_error only.
REQ-032 After keys 5,9, drop vehicle_arrival in the same cycle as key 9 -> IDLE, digit_count=0, code=0; keys while vehicle_arrival=0 are ignored.
REQ-033 With KEYPAD_TIMEOUT_EN and TIMEOUT_CYCLES=16: key 5, then 16 idle cycles -> entry_error pulse at cycle 15, digit_count=0; without the macro, digit_count stays 1.
REQ-034 Assert rst in the SUBMIT cycle -> code_ack=0 immediately and all outputs at reset values.
